uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning data bits per frame (5..9).
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 2520, meaning clk cycles per bit (24.19 MHz / 9600 baud), minimum 8.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 16, meaning receive FIFO entries, a power of two, at least 2.
REQ-004 The block SHALL have parameter PARITY_ODD, default 0, meaning odd parity when 1 and even parity when 0; it is used only with UART_PARITY_EN.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port serial_in, input, 1 bit: asynchronous UART line, idle high.
REQ-008 The block SHALL have port rd_en, input, 1 bit: pops the FIFO head.
REQ-009 The block SHALL have port err_clr, input, 1 bit: clears the sticky overrun flag.
REQ-010 The block SHALL have port rd_data, output, DATA_W bits: FIFO head (show-ahead), valid while empty=0.
REQ-011 The block SHALL have port empty, output, 1 bit: FIFO empty.
REQ-012 The block SHALL have port full, output, 1 bit: FIFO full.
REQ-013 The block SHALL have port count, output, clog2(FIFO_DEPTH)+1 bits: FIFO occupancy.
REQ-014 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse on a bad stop bit.
REQ-015 The block SHALL have port parity_err, output, 1 bit: one-cycle pulse on a parity mismatch.
REQ-016 The block SHALL have port overrun, output, 1 bit: sticky flag, set when a byte is dropped because the FIFO is full.

Function
REQ-017 serial_in SHALL pass through a 2-flop synchronizer; all receiver decisions use the synchronized value, so detection latency is 2 cycles.
REQ-018 The receiver FSM SHALL have states IDLE, START, DATA, PARITY, STOP and RECOVER.
REQ-019 IDLE SHALL move to START on a synchronized high-to-low transition.
REQ-020 START SHALL wait CLKS_PER_BIT/2 cycles and then resample: low moves to DATA, high (glitch) returns to IDLE with no flags raised.
REQ-021 DATA SHALL sample once every CLKS_PER_BIT cycles, shift LSB first, and leave after DATA_W samples.
REQ-022 STOP SHALL sample after CLKS_PER_BIT cycles: a high sample pushes the word and returns to IDLE; a low sample pulses frame_err, discards the word and moves to RECOVER.
REQ-023 RECOVER SHALL wait for a synchronized high and then go to IDLE, so a break condition produces exactly one frame_err.
REQ-024 A push SHALL occur in the cycle the stop bit is sampled; empty SHALL deassert and count SHALL increment on the next clock edge.
REQ-025 rd_en with empty=0 SHALL advance the head on the next edge; rd_en with empty=1 SHALL be ignored, with no underflow and no pointer change.
REQ-026 A push while full without a simultaneous pop SHALL drop the word and set overrun.
REQ-027 A push while full with a simultaneous rd_en SHALL be accepted, leaving count unchanged at FIFO_DEPTH.
REQ-028 A simultaneous push and pop at any other occupancy SHALL leave count unchanged.
REQ-029 Pointers SHALL wrap modulo FIFO_DEPTH; full SHALL equal (count==FIFO_DEPTH) and empty SHALL equal (count==0).
REQ-030 err_clr SHALL clear overrun on the next edge; when it coincides with a new overrun event, set SHALL win.

Reset
REQ-031 While rst_n=0 the block SHALL force: FSM=IDLE, synchronizer=1, pointers=0, count=0, empty=1, full=0, rd_data=0, frame_err=0, parity_err=0, overrun=0.
REQ-032 Reset asserted mid-frame SHALL abandon the frame without a push or flag; after release, a line still low SHALL NOT start a frame until it has been seen high.

Configuration
REQ-033 With macro UART_PARITY_EN defined, DATA SHALL proceed to PARITY, which samples one bit after CLKS_PER_BIT cycles.
REQ-034 With UART_PARITY_EN defined, a parity mismatch against PARITY_ODD SHALL pulse parity_err and discard the word; the STOP check still runs.
REQ-035 Without UART_PARITY_EN, the PARITY state logic SHALL NOT be built, DATA SHALL go directly to STOP, and parity_err SHALL be tied to 0.

Verification
REQ-036 With CLKS_PER_BIT=16, a frame carrying 0x55 followed by 0xA3 SHALL produce rd_data=0x55 then 0xA3 after rd_en, with count reaching 2.
REQ-037 A 4-cycle low glitch on serial_in SHALL cause no push, empty to remain 1 and no flags.
REQ-038 A frame carrying 0x3C with its stop bit held low for 20 bit times SHALL produce exactly one frame_err pulse, empty=1, and correct reception of the next frame.
REQ-039 With FIFO_DEPTH=4 and 5 frames sent without reads, full SHALL be 1, overrun SHALL be 1, words 1-4 SHALL read back intact, and err_clr SHALL then clear overrun.
REQ-040 rst_n pulsed low during bit 4 of a frame SHALL give count=0 after release with no flags, and the next frame 0x81 SHALL be received correctly.
REQ-041 With UART_PARITY_EN defined and PARITY_ODD=0, 0x07 sent with parity bit 0 SHALL produce parity_err=1 and no push, and 0x07 with parity bit 1 SHALL be pushed.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver feeding a show-ahead receive FIFO.
//
// Optional feature macro: UART_PARITY_EN
//   When defined, the frame carries one parity bit after the data bits and
//   parity_err is live. Otherwise the parity state logic is not built and
//   parity_err is tied to 0.
//
// Parameters
//   DATA_W       data bits per frame (5..9)
//   CLKS_PER_BIT clk cycles per bit period (>= 8)
//   FIFO_DEPTH   receive FIFO entries (power of two, >= 2)
//   PARITY_ODD   1 = odd parity, 0 = even parity (UART_PARITY_EN builds only)
//
// Ports
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   serial_in  asynchronous UART line, idle high
//   rd_en      pop the FIFO head (ignored while empty)
//   err_clr    clear the sticky overrun flag
//   rd_data    FIFO head (show-ahead), valid while empty = 0, 0 when empty
//   empty      FIFO empty
//   full       FIFO full
//   count      FIFO occupancy
//   frame_err  one-cycle pulse on a low stop bit
//   parity_err one-cycle pulse on a parity mismatch
//   overrun    sticky: a received word was dropped because the FIFO was full
//
// Read handshake: a pop happens on the rising edge where rd_en = 1 and
// empty = 0; rd_data then shows the next entry from that edge onward.

module uart_rx_fifo #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 2520,
    parameter int FIFO_DEPTH   = 16,
    parameter int PARITY_ODD   = 0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            serial_in,
    input  logic                            rd_en,
    input  logic                            err_clr,
    output logic [DATA_W-1:0]               rd_data,
    output logic                            empty,
    output logic                            full,
    output logic [$clog2(FIFO_DEPTH):0]     count,
    output logic                            frame_err,
    output logic                            parity_err,
    output logic                            overrun
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = $clog2(CLKS_PER_BIT);
    localparam int BW    = $clog2(DATA_W);
    localparam int CNT_W = AW + 1;

    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] IDX_LAST  = BW'(DATA_W - 1);

    // Out-of-range parameters elaborate this empty marker block so they are
    // easy to spot in a hierarchy dump.
    if (DATA_W < 5 || DATA_W > 9 || CLKS_PER_BIT < 8 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || PARITY_ODD < 0 || PARITY_ODD > 1)
    begin : g_bad_params
    end

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, RECOVER
    } state_t;

    state_t             state;
    logic [1:0]         sync;
    logic [1:0]         fill;
    logic               rx_s;
    logic               rx_prev;
    logic               armed;
    logic [CW-1:0]      cnt;
    logic [BW-1:0]      bit_idx;
    logic [DATA_W-1:0]  shreg;
    logic               push;
    logic               pop;
    logic               do_push;

    assign rx_s = sync[1];

    // fill tracks when the synchronizer holds real line samples rather than
    // its reset value. armed only rises once the line has truly been seen
    // high, so a line held low across reset cannot fake a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync    <= 2'b11;
            fill    <= 2'b00;
            rx_prev <= 1'b1;
            armed   <= 1'b0;
        end else begin
            sync    <= {sync[0], serial_in};
            fill    <= {fill[0], 1'b1};
            rx_prev <= rx_s;
            armed   <= armed | (fill[1] & rx_s);
        end
    end

`ifdef UART_PARITY_EN
    logic par_bad;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            frame_err <= 1'b0;
`ifdef UART_PARITY_EN
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
`ifdef UART_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
`ifdef UART_PARITY_EN
                    par_bad <= 1'b0;
`endif
                    if (armed && rx_prev && !rx_s) state <= START;
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt   <= '0;
                        // A line back high at mid start bit was a glitch.
                        state <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        shreg <= {rx_s, shreg[DATA_W-1:1]};
                        if (bit_idx == IDX_LAST) begin
                            bit_idx <= '0;
`ifdef UART_PARITY_EN
                            state   <= PARITY;
`else
                            state   <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef UART_PARITY_EN
                PARITY: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        state <= STOP;
                        if ((^shreg ^ rx_s) != PARITY_ODD[0]) begin
                            par_bad    <= 1'b1;
                            parity_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            state <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= RECOVER;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RECOVER: begin
                    // Hold here through a break so it yields one frame_err.
                    if (rx_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef UART_PARITY_EN
    assign push = (state == STOP) && (cnt == BIT_LAST) && rx_s && !par_bad;
`else
    assign push = (state == STOP) && (cnt == BIT_LAST) && rx_s;
    assign parity_err = 1'b0;
`endif

    // Receive FIFO
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CNT_W-1:0]  count_q;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(FIFO_DEPTH));
    assign count   = count_q;
    assign pop     = rd_en && !empty;
    // A full FIFO still accepts a push when the head is popped in the same cycle.
    assign do_push = push && (!full || pop);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            overrun <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            // A new drop wins over a simultaneous clear.
            if (push && !do_push) overrun <= 1'b1;
            else if (err_clr)     overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed testbench for uart_rx_fifo (CLKS_PER_BIT=16, FIFO_DEPTH=4).
// Works in both the default build and with UART_PARITY_EN defined.

module tb_uart_rx_fifo;

    localparam int DATA_W = 8;
    localparam int CPB    = 16;
    localparam int DEPTH  = 4;
`ifdef UART_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              serial_in = 1'b1;
    logic              rd_en = 1'b0;
    logic              err_clr = 1'b0;
    logic [DATA_W-1:0] rd_data;
    logic              empty;
    logic              full;
    logic [2:0]        count;
    logic              frame_err;
    logic              parity_err;
    logic              overrun;

    int tests_run = 0;
    int tests_failed = 0;
    int fe_cnt = 0;
    int pe_cnt = 0;

    uart_rx_fifo #(
        .DATA_W(DATA_W), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .PARITY_ODD(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .serial_in(serial_in), .rd_en(rd_en),
        .err_clr(err_clr), .rd_data(rd_data), .empty(empty), .full(full),
        .count(count), .frame_err(frame_err), .parity_err(parity_err),
        .overrun(overrun)
    );

    // clock / reset
    always #5 clk = ~clk;

    // flag pulse counters, sampled away from the active edge
    always @(negedge clk) begin
        if (frame_err)  fe_cnt++;
        if (parity_err) pe_cnt++;
    end

    // driver tasks
    task automatic drive_bit(input logic b);
        serial_in = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        serial_in = 1'b1;
        repeat (n * CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_en,
                              input logic par_bit, input int stop_low_bits);
        drive_bit(1'b0);
        for (int i = 0; i < DATA_W; i++) drive_bit(d[i]);
        if (par_en) drive_bit(par_bit);
        repeat (stop_low_bits) drive_bit(1'b0);
        drive_bit(1'b1);
        idle_bits(1);
    endtask

    task automatic send_good(input logic [7:0] d);
        send_frame(d, PAR, ^d, 0);
    endtask

    task automatic pop_one();
        @(negedge clk) rd_en = 1'b1;
        @(negedge clk) rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (empty !== 1'b1 || full !== 1'b0 || count !== 3'd0) begin
            $display("FAIL reset_fifo: got empty=%b full=%b count=%0d expected 1 0 0", empty, full, count);
            tests_failed++;
        end
        tests_run++;
        if (rd_data !== 8'h00) begin
            $display("FAIL reset_rd_data: got %h expected 00", rd_data);
            tests_failed++;
        end
        tests_run++;
        if (frame_err !== 1'b0 || parity_err !== 1'b0 || overrun !== 1'b0) begin
            $display("FAIL reset_flags: got fe=%b pe=%b ov=%b expected 0 0 0", frame_err, parity_err, overrun);
            tests_failed++;
        end
        rst_n = 1'b1;
        idle_bits(2);
    endtask

    task automatic test_basic();
        send_good(8'h55);
        send_good(8'hA3);
        tests_run++;
        if (count !== 3'd2 || empty !== 1'b0) begin
            $display("FAIL basic_count: got count=%0d empty=%b expected 2 0", count, empty);
            tests_failed++;
        end
        tests_run++;
        if (rd_data !== 8'h55) begin
            $display("FAIL basic_first: got %h expected 55", rd_data);
            tests_failed++;
        end
        pop_one();
        tests_run++;
        if (rd_data !== 8'hA3 || count !== 3'd1) begin
            $display("FAIL basic_second: got %h count=%0d expected a3 count=1", rd_data, count);
            tests_failed++;
        end
        pop_one();
        tests_run++;
        if (empty !== 1'b1 || count !== 3'd0) begin
            $display("FAIL basic_drain: got empty=%b count=%0d expected 1 0", empty, count);
            tests_failed++;
        end
        // pop on empty must be ignored
        pop_one();
        tests_run++;
        if (empty !== 1'b1 || count !== 3'd0) begin
            $display("FAIL underflow: got empty=%b count=%0d expected 1 0", empty, count);
            tests_failed++;
        end
    endtask

    task automatic test_glitch();
        int fe0 = fe_cnt;
        serial_in = 1'b0;
        repeat (4) @(negedge clk);
        idle_bits(3);
        tests_run++;
        if (empty !== 1'b1 || count !== 3'd0 || fe_cnt != fe0 || overrun !== 1'b0) begin
            $display("FAIL glitch: got empty=%b count=%0d fe=%0d ov=%b expected 1 0 0 0",
                     empty, count, fe_cnt - fe0, overrun);
            tests_failed++;
        end
    endtask

    task automatic test_break();
        int fe0 = fe_cnt;
        send_frame(8'h3C, PAR, ^8'h3C, 20);
        idle_bits(1);
        tests_run++;
        if (fe_cnt - fe0 != 1) begin
            $display("FAIL break_frame_err: got %0d pulses expected 1", fe_cnt - fe0);
            tests_failed++;
        end
        tests_run++;
        if (empty !== 1'b1) begin
            $display("FAIL break_empty: got empty=%b expected 1", empty);
            tests_failed++;
        end
        send_good(8'h5A);
        tests_run++;
        if (rd_data !== 8'h5A || count !== 3'd1) begin
            $display("FAIL break_next: got %h count=%0d expected 5a count=1", rd_data, count);
            tests_failed++;
        end
        pop_one();
    endtask

    task automatic test_overrun();
        logic [7:0] exp_q[$];
        logic [7:0] vals[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        for (int i = 0; i < 5; i++) begin
            send_good(vals[i]);
            if (i < DEPTH) exp_q.push_back(vals[i]);
        end
        tests_run++;
        if (full !== 1'b1 || count !== 3'd4 || overrun !== 1'b1) begin
            $display("FAIL overrun_full: got full=%b count=%0d ov=%b expected 1 4 1", full, count, overrun);
            tests_failed++;
        end
        while (exp_q.size() > 0) begin
            logic [7:0] e = exp_q.pop_front();
            tests_run++;
            if (rd_data !== e) begin
                $display("FAIL overrun_readback: got %h expected %h", rd_data, e);
                tests_failed++;
            end
            pop_one();
        end
        tests_run++;
        if (empty !== 1'b1 || overrun !== 1'b1) begin
            $display("FAIL overrun_sticky: got empty=%b ov=%b expected 1 1", empty, overrun);
            tests_failed++;
        end
        @(negedge clk) err_clr = 1'b1;
        @(negedge clk) err_clr = 1'b0;
        tests_run++;
        if (overrun !== 1'b0) begin
            $display("FAIL overrun_clear: got %b expected 0", overrun);
            tests_failed++;
        end
    endtask

    task automatic test_reset_mid();
        int fe0 = fe_cnt;
        int pe0 = pe_cnt;
        // frame of 0x00: line low through start and bits 0..3, reset in bit 4
        serial_in = 1'b0;
        repeat (4 * CPB + CPB + CPB / 2) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4 * CPB) @(negedge clk);
        idle_bits(3);
        tests_run++;
        if (count !== 3'd0 || empty !== 1'b1 || fe_cnt != fe0 || pe_cnt != pe0 || overrun !== 1'b0) begin
            $display("FAIL reset_mid: got count=%0d empty=%b fe=%0d pe=%0d ov=%b expected 0 1 0 0 0",
                     count, empty, fe_cnt - fe0, pe_cnt - pe0, overrun);
            tests_failed++;
        end
        send_good(8'h81);
        tests_run++;
        if (rd_data !== 8'h81 || count !== 3'd1) begin
            $display("FAIL reset_mid_next: got %h count=%0d expected 81 count=1", rd_data, count);
            tests_failed++;
        end
        pop_one();
    endtask

`ifdef UART_PARITY_EN
    task automatic test_parity();
        int pe0 = pe_cnt;
        send_frame(8'h07, 1'b1, 1'b0, 0);
        tests_run++;
        if (pe_cnt - pe0 != 1 || empty !== 1'b1) begin
            $display("FAIL parity_bad: got pe=%0d empty=%b expected 1 1", pe_cnt - pe0, empty);
            tests_failed++;
        end
        send_frame(8'h07, 1'b1, 1'b1, 0);
        tests_run++;
        if (rd_data !== 8'h07 || count !== 3'd1 || pe_cnt - pe0 != 1) begin
            $display("FAIL parity_good: got %h count=%0d pe=%0d expected 07 1 1", rd_data, count, pe_cnt - pe0);
            tests_failed++;
        end
        pop_one();
    endtask
`else
    task automatic test_parity();
        tests_run++;
        if (pe_cnt != 0) begin
            $display("FAIL parity_tied: got %0d pulses expected 0", pe_cnt);
            tests_failed++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_break();
        test_overrun();
        test_reset_mid();
        test_parity();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
